wb_stage_param: RTL and testbench

- Parametrised, registered successor of the combinational write-back stage.
- Captures MEM-stage results into an internal MEM/WB register and selects load data or ALU result.
- Sizes and extends sub-word loads; honours pipeline freeze and flush.
- Serialises dual register writes (load plus base-register writeback) onto the single register-file write port with a 2-state FSM, back-pressuring the pipeline for one cycle.

---
 rtl/wb_stage_param.sv | 157 +++++++++++++++
 tb/tb_wb_stage_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_param.sv
// ============================================================================
// Module      : wb_stage_param
// Description : Registered write-back stage with sub-word load extraction and
//               serialisation of dual (load + base-register) writes.
//               Optional retire counter enabled by macro WB_RETIRE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage_param #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     alu_res,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  mem_r_en,
    input  logic [1:0]            mem_size,
    input  logic                  mem_signed,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  base_wb_en,
    input  logic [REG_ADDR_W-1:0] base_dest,
    input  logic [DATA_W-1:0]     base_value,
    output logic [ADDR_W-1:0]     pc,
    output logic [DATA_W-1:0]     wb_value,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  wb_wb_en,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]           retire_cnt,
`endif
    output logic                  stall_out
);

    localparam int LANE_W = $clog2(DATA_W / 8);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_pc,         w_pc_nxt;
    logic [DATA_W-1:0]     r_value,      w_value_nxt;
    logic [REG_ADDR_W-1:0] r_dest,       w_dest_nxt;
    logic                  r_en,         w_en_nxt;
    logic [REG_ADDR_W-1:0] r_pend_dest,  w_pend_dest_nxt;
    logic [DATA_W-1:0]     r_pend_value, w_pend_value_nxt;

    logic [LANE_W-1:0]     w_lane;
    logic [LANE_W-1:0]     w_half_lane;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_W-1:0]     w_load_ext;
    logic [DATA_W-1:0]     w_sel;

    // Little-endian lanes; a half-word access ignores address bit 0.
    assign w_lane      = alu_res[LANE_W-1:0];
    assign w_half_lane = w_lane & ~LANE_W'(1);
    assign w_byte      = mem_data[{w_lane, 3'b000} +: 8];
    assign w_half      = mem_data[{w_half_lane, 3'b000} +: 16];

    always_comb begin
        w_load_ext = mem_data;
        case (mem_size)
            2'b00: w_load_ext = {{(DATA_W-8){mem_signed & w_byte[7]}}, w_byte};
            2'b01: w_load_ext = {{(DATA_W-16){mem_signed & w_half[15]}}, w_half};
            default: w_load_ext = mem_data;
        endcase
    end

    assign w_sel = mem_r_en ? w_load_ext : alu_res;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_value_nxt      = r_value;
        w_dest_nxt       = r_dest;
        w_en_nxt         = r_en;
        w_pend_dest_nxt  = r_pend_dest;
        w_pend_value_nxt = r_pend_value;

        if (r_state == ST_SECOND) begin
            // Already-committed base write completes regardless of flush/inputs.
            w_value_nxt = r_pend_value;
            w_dest_nxt  = r_pend_dest;
            w_en_nxt    = 1'b1;
            w_state_nxt = ST_RUN;
        end else if (flush) begin
            w_pc_nxt = pc_in;
            w_en_nxt = 1'b0;
        end else begin
            w_pc_nxt    = pc_in;
            w_value_nxt = w_sel;
            w_dest_nxt  = dest;
            w_en_nxt    = wb_en;
            if (base_wb_en && !wb_en) begin
                w_value_nxt = base_value;
                w_dest_nxt  = base_dest;
                w_en_nxt    = 1'b1;
            end else if (base_wb_en && wb_en && (dest != base_dest)) begin
                w_pend_dest_nxt  = base_dest;
                w_pend_value_nxt = base_value;
                w_state_nxt      = ST_SECOND;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= '0;
            r_value      <= '0;
            r_dest       <= '0;
            r_en         <= 1'b0;
            r_pend_dest  <= '0;
            r_pend_value <= '0;
        end else if (!freeze) begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_value      <= w_value_nxt;
            r_dest       <= w_dest_nxt;
            r_en         <= w_en_nxt;
            r_pend_dest  <= w_pend_dest_nxt;
            r_pend_value <= w_pend_value_nxt;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (!freeze && w_en_nxt) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

    assign pc        = r_pc;
    assign wb_value  = r_value;
    assign wb_dest   = r_dest;
    assign wb_wb_en  = r_en;
    assign stall_out = (r_state == ST_SECOND);

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_param.sv
// ============================================================================
// Module      : tb_wb_stage_param
// Description : Scoreboard testbench for wb_stage_param.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_param;

    logic        clk = 1'b0;
    logic        rst, freeze, flush;
    logic [31:0] pc_in, alu_res, mem_data, base_value;
    logic        mem_r_en, mem_signed, wb_en, base_wb_en;
    logic [1:0]  mem_size;
    logic [3:0]  dest, base_dest;
    logic [31:0] pc, wb_value;
    logic [3:0]  wb_dest;
    logic        wb_wb_en, stall_out;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    always #5 clk = ~clk;

    wb_stage_param #(.DATA_W(32), .REG_ADDR_W(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .pc_in(pc_in), .alu_res(alu_res), .mem_data(mem_data),
        .mem_r_en(mem_r_en), .mem_size(mem_size), .mem_signed(mem_signed),
        .wb_en(wb_en), .dest(dest), .base_wb_en(base_wb_en),
        .base_dest(base_dest), .base_value(base_value),
        .pc(pc), .wb_value(wb_value), .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .stall_out(stall_out)
    );

    typedef struct packed {
        logic        rst, frz, fl;
        logic [31:0] pc, alu, mem;
        logic        rd;
        logic [1:0]  sz;
        logic        sg, we;
        logic [3:0]  d;
        logic        bwe;
        logic [3:0]  bd;
        logic [31:0] bv;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val;
        logic [3:0]  dest;
        logic        en;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    function automatic stim_t S(logic r, logic fz, logic fl, logic [31:0] p,
                                logic [31:0] a, logic [31:0] m, logic rd,
                                logic [1:0] sz, logic sg, logic we, logic [3:0] d,
                                logic bwe, logic [3:0] bd, logic [31:0] bv);
        S = '{rst:r, frz:fz, fl:fl, pc:p, alu:a, mem:m, rd:rd, sz:sz, sg:sg,
              we:we, d:d, bwe:bwe, bd:bd, bv:bv};
    endfunction

    function automatic exp_t E(logic [31:0] p, logic [31:0] v, logic [3:0] d,
                               logic en, logic st);
        E = '{pc:p, val:v, dest:d, en:en, stall:st};
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; freeze = s.frz; flush = s.fl; pc_in = s.pc;
        alu_res = s.alu; mem_data = s.mem; mem_r_en = s.rd; mem_size = s.sz;
        mem_signed = s.sg; wb_en = s.we; dest = s.d; base_wb_en = s.bwe;
        base_dest = s.bd; base_value = s.bv;
    endtask

    // Idle stimulus used as a bubble: flush with everything else quiet.
    function automatic stim_t BUB(logic [31:0] p);
        BUB = S(0, 0, 1, p, 32'h0, 32'h0, 0, 2'b10, 0, 0, 4'h0, 0, 4'h0, 32'h0);
    endfunction

    task automatic test_reset();
        stim_t sq[$]; exp_t eq[$]; exp_t got, obs;
        sq.push_back(S(1, 0, 0, 32'hFF, 32'h5, 32'h0, 0, 2'b10, 0, 1, 4'h3, 1, 4'h4, 32'h9)); eq.push_back(E(0, 0, 0, 0, 0));
        sq.push_back(S(1, 0, 0, 32'hFF, 32'h5, 32'h0, 0, 2'b10, 0, 1, 4'h3, 1, 4'h4, 32'h9)); eq.push_back(E(0, 0, 0, 0, 0));
        sq.push_back(S(0, 0, 0, 32'h10, 32'h1234, 32'h0, 0, 2'b10, 0, 1, 4'h3, 0, 4'h0, 32'h0)); eq.push_back(E(32'h10, 32'h1234, 3, 1, 0));
        foreach (sq[i]) begin
            apply(sq[i]); exp_q.push_back(eq[i]);
            @(posedge clk); #1;
            got = exp_q.pop_front(); obs = {pc, wb_value, wb_dest, wb_wb_en, stall_out};
            total++;
            if (obs !== got) $display("FAIL reset step %0d: got %h required %h", i, obs, got);
            else passed++;
        end
    endtask

    task automatic test_loads();
        stim_t sq[$]; exp_t eq[$]; exp_t got, obs;
        sq.push_back(S(0, 0, 0, 32'h20, 32'h1003, 32'h80FF7F01, 1, 2'b00, 1, 1, 4'h1, 0, 4'h0, 0)); eq.push_back(E(32'h20, 32'hFFFFFF80, 1, 1, 0));
        sq.push_back(S(0, 0, 0, 32'h24, 32'h1003, 32'h80FF7F01, 1, 2'b00, 0, 1, 4'h2, 0, 4'h0, 0)); eq.push_back(E(32'h24, 32'h00000080, 2, 1, 0));
        sq.push_back(S(0, 0, 0, 32'h28, 32'h1003, 32'h80FF7F01, 1, 2'b01, 1, 1, 4'h3, 0, 4'h0, 0)); eq.push_back(E(32'h28, 32'hFFFF80FF, 3, 1, 0));
        sq.push_back(S(0, 0, 0, 32'h2C, 32'h1001, 32'h80FF7F01, 1, 2'b01, 1, 1, 4'h4, 0, 4'h0, 0)); eq.push_back(E(32'h2C, 32'h00007F01, 4, 1, 0));
        sq.push_back(S(0, 0, 0, 32'h30, 32'h1002, 32'h80FF7F01, 1, 2'b01, 0, 1, 4'h5, 0, 4'h0, 0)); eq.push_back(E(32'h30, 32'h000080FF, 5, 1, 0));
        sq.push_back(S(0, 0, 0, 32'h34, 32'h1001, 32'h80FF7F01, 1, 2'b00, 1, 1, 4'h6, 0, 4'h0, 0)); eq.push_back(E(32'h34, 32'h0000007F, 6, 1, 0));
        sq.push_back(S(0, 0, 0, 32'h38, 32'h1002, 32'h80FF7F01, 1, 2'b10, 1, 1, 4'h7, 0, 4'h0, 0)); eq.push_back(E(32'h38, 32'h80FF7F01, 7, 1, 0));
        sq.push_back(S(0, 0, 0, 32'h3C, 32'h1003, 32'h80FF7F01, 1, 2'b11, 0, 1, 4'h8, 0, 4'h0, 0)); eq.push_back(E(32'h3C, 32'h80FF7F01, 8, 1, 0));
        sq.push_back(S(0, 0, 0, 32'h40, 32'h1003, 32'h80FF7F01, 0, 2'b00, 1, 1, 4'h9, 0, 4'h0, 0)); eq.push_back(E(32'h40, 32'h00001003, 9, 1, 0));
        foreach (sq[i]) begin
            apply(sq[i]); exp_q.push_back(eq[i]);
            @(posedge clk); #1;
            got = exp_q.pop_front(); obs = {pc, wb_value, wb_dest, wb_wb_en, stall_out};
            total++;
            if (obs !== got) $display("FAIL load step %0d: got %h required %h", i, obs, got);
            else passed++;
        end
    endtask

    task automatic test_dual_write();
        stim_t sq[$]; exp_t eq[$]; exp_t got, obs;
        sq.push_back(S(0, 0, 0, 32'h50, 32'h0, 32'hCAFE, 1, 2'b10, 0, 1, 4'h1, 1, 4'h2, 32'h100)); eq.push_back(E(32'h50, 32'hCAFE, 1, 1, 1));
        sq.push_back(S(0, 0, 0, 32'h54, 32'h5555, 32'h0, 0, 2'b10, 0, 1, 4'hB, 1, 4'hC, 32'hDEAD)); eq.push_back(E(32'h50, 32'h100, 2, 1, 0));
        sq.push_back(BUB(32'h58)); eq.push_back(E(32'h58, 32'h100, 2, 0, 0));
        sq.push_back(S(0, 0, 0, 32'h5C, 32'h0, 32'h55AA, 1, 2'b10, 0, 1, 4'h5, 1, 4'h5, 32'h999)); eq.push_back(E(32'h5C, 32'h55AA, 5, 1, 0));
        sq.push_back(BUB(32'h60)); eq.push_back(E(32'h60, 32'h55AA, 5, 0, 0));
        sq.push_back(S(0, 0, 0, 32'h64, 32'h1, 32'h0, 0, 2'b10, 0, 0, 4'h3, 1, 4'h7, 32'h777)); eq.push_back(E(32'h64, 32'h777, 7, 1, 0));
        foreach (sq[i]) begin
            apply(sq[i]); exp_q.push_back(eq[i]);
            @(posedge clk); #1;
            got = exp_q.pop_front(); obs = {pc, wb_value, wb_dest, wb_wb_en, stall_out};
            total++;
            if (obs !== got) $display("FAIL dual step %0d: got %h required %h", i, obs, got);
            else passed++;
        end
    endtask

    task automatic test_freeze_flush();
        stim_t sq[$]; exp_t eq[$]; exp_t got, obs;
        sq.push_back(S(0, 0, 0, 32'h80, 32'h44, 32'h0, 0, 2'b10, 0, 1, 4'h4, 1, 4'h6, 32'h600)); eq.push_back(E(32'h80, 32'h44, 4, 1, 1));
        for (int k = 0; k < 3; k++) begin
            sq.push_back(S(0, 1, k[0], 32'hEE0 + k, 32'hABC, 32'h0, 0, 2'b10, 0, 1, 4'hE, 1, 4'hF, 32'hBAD));
            eq.push_back(E(32'h80, 32'h44, 4, 1, 1));
        end
        sq.push_back(S(0, 0, 1, 32'h84, 32'h77, 32'h0, 0, 2'b10, 0, 1, 4'h1, 1, 4'h2, 32'h3)); eq.push_back(E(32'h80, 32'h600, 6, 1, 0));
        sq.push_back(BUB(32'h90)); eq.push_back(E(32'h90, 32'h600, 6, 0, 0));
        sq.push_back(S(0, 1, 0, 32'hA0, 32'h1, 32'h0, 0, 2'b10, 0, 1, 4'h1, 0, 4'h0, 32'h0)); eq.push_back(E(32'h90, 32'h600, 6, 0, 0));
        foreach (sq[i]) begin
            apply(sq[i]); exp_q.push_back(eq[i]);
            @(posedge clk); #1;
            got = exp_q.pop_front(); obs = {pc, wb_value, wb_dest, wb_wb_en, stall_out};
            total++;
            if (obs !== got) $display("FAIL freeze_flush step %0d: got %h required %h", i, obs, got);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t sq[$]; exp_t eq[$]; exp_t got, obs;
        sq.push_back(S(0, 0, 0, 32'hB0, 32'h88, 32'h0, 0, 2'b10, 0, 1, 4'h8, 1, 4'h9, 32'h900)); eq.push_back(E(32'hB0, 32'h88, 8, 1, 1));
        sq.push_back(S(0, 0, 0, 32'hB4, 32'hAA, 32'h0, 0, 2'b10, 0, 1, 4'hA, 1, 4'hB, 32'hB00)); eq.push_back(E(32'hB0, 32'h900, 9, 1, 0));
        sq.push_back(S(0, 0, 0, 32'hB4, 32'hAA, 32'h0, 0, 2'b10, 0, 1, 4'hA, 1, 4'hB, 32'hB00)); eq.push_back(E(32'hB4, 32'hAA, 10, 1, 1));
        sq.push_back(S(0, 0, 0, 32'hB4, 32'hAA, 32'h0, 0, 2'b10, 0, 1, 4'hA, 1, 4'hB, 32'hB00)); eq.push_back(E(32'hB4, 32'hB00, 11, 1, 0));
        sq.push_back(S(0, 0, 0, 32'hC0, 32'hC, 32'h0, 0, 2'b10, 0, 1, 4'h1, 1, 4'h2, 32'h222)); eq.push_back(E(32'hC0, 32'hC, 1, 1, 1));
        sq.push_back(S(1, 0, 0, 32'hC0, 32'hC, 32'h0, 0, 2'b10, 0, 1, 4'h1, 1, 4'h2, 32'h222)); eq.push_back(E(0, 0, 0, 0, 0));
        sq.push_back(BUB(32'hC4)); eq.push_back(E(32'hC4, 0, 0, 0, 0));
        foreach (sq[i]) begin
            apply(sq[i]); exp_q.push_back(eq[i]);
            @(posedge clk); #1;
            got = exp_q.pop_front(); obs = {pc, wb_value, wb_dest, wb_wb_en, stall_out};
            total++;
            if (obs !== got) $display("FAIL back_to_back step %0d: got %h required %h", i, obs, got);
            else passed++;
        end
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_retire_cnt();
        apply(S(1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        for (int k = 0; k < 7; k++) begin
            if (k == 2 || k == 5) apply(BUB(32'h100 + k));
            else apply(S(0, 0, 0, 32'h100 + k, k, 0, 0, 2'b10, 0, 1, 4'h1, 0, 0, 0));
            @(posedge clk); #1;
        end
        total++;
        if (retire_cnt !== 32'd5) $display("FAIL retire_cnt: got %0d required 5", retire_cnt);
        else passed++;
    endtask
`endif

    initial begin
        apply(BUB(0));
        rst = 1'b1;
        test_reset();
        test_loads();
        test_dual_write();
        test_freeze_flush();
        test_back_to_back();
`ifdef WB_RETIRE_CNT_EN
        test_retire_cnt();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
